// File: rtl/hopfield_recall_engine.sv
// Hopfield associative memory with on-chip Hebbian training and sequential
// (one neuron per clock) recall, convergence detection and a sweep limit.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high exactly while the engine is idle.
// The requester holds cmd_valid, cmd_op and pattern_input stable until the
// transfer edge. Nothing is sampled from those inputs on any other edge.
module hopfield_recall_engine #(
   parameter int NEURON_COUNT = 16,
   parameter int MAX_PATTERNS = 4,
   parameter int MAX_SWEEPS   = 8,
   localparam int SCW = $clog2(MAX_SWEEPS + 1),
   localparam int PCW = $clog2(MAX_PATTERNS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [NEURON_COUNT-1:0] pattern_input,
   output logic [NEURON_COUNT-1:0] neuron_states,
   output logic                    done,
   output logic                    converged,
   output logic [SCW-1:0]          sweep_count,
   output logic [PCW-1:0]          pattern_count,
   output logic                    store_overflow,
   output logic                    fsm_state
);

   localparam int N  = NEURON_COUNT;
   localparam int WW = PCW + 1;          // weight width, holds +/-MAX_PATTERNS
   localparam int IW = $clog2(N);        // neuron index width
   localparam int HW = WW + IW + 1;      // local field accumulator width

   localparam logic [1:0] OP_STORE  = 2'b00;
   localparam logic [1:0] OP_RECALL = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RECALL = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic signed [WW-1:0] w [N][N];
   logic [IW-1:0]        idx;
   logic                 changed;

   logic signed [HW-1:0] h;
   logic                 new_bit;
   logic                 flip;
   logic                 last_neuron;
   logic                 sweep_stable;
   logic                 sweep_limit;
   logic                 recall_end;
   logic                 xfer;

   assign cmd_ready = (state == ST_IDLE);
   assign fsm_state = state;
   assign xfer      = cmd_valid && cmd_ready;

   // Local field of the neuron under update and its thresholded new value.
   always_comb begin
      h = '0;
      for (int j = 0; j < N; j++) begin
         if (neuron_states[j]) h = h + HW'(w[idx][j]);
         else                  h = h - HW'(w[idx][j]);
      end
      if (h[HW-1])        new_bit = 1'b0;              // h < 0
      else if (h == '0)   new_bit = neuron_states[idx]; // tie keeps state
      else                new_bit = 1'b1;              // h > 0
      flip         = (new_bit != neuron_states[idx]);
      last_neuron  = (idx == IW'(N - 1));
      sweep_stable = !(changed | flip);
      sweep_limit  = (({1'b0, sweep_count} + 1'b1) == (SCW + 1)'(MAX_SWEEPS));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: recall starts on a recall transfer and ends at the last
   // neuron of a sweep that was either stable or the final allowed sweep.
   always_comb begin
      state_nxt  = state;
      recall_end = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer && (cmd_op == OP_RECALL)) state_nxt = ST_RECALL;
         end
         ST_RECALL: begin
            if (last_neuron && (sweep_stable || sweep_limit)) begin
               recall_end = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Weight memory, pattern counter and overflow flag (store / clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               w[i][j] <= '0;
         pattern_count  <= '0;
         store_overflow <= 1'b0;
      end else if (xfer && (cmd_op == OP_STORE)) begin
         if (pattern_count < PCW'(MAX_PATTERNS)) begin
            // Diagonal is never written, so it stays zero.
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  if (i != j)
                     w[i][j] <= (pattern_input[i] == pattern_input[j]) ?
                                w[i][j] + WW'(1) : w[i][j] - WW'(1);
            pattern_count <= pattern_count + 1'b1;
         end else begin
            store_overflow <= 1'b1;
         end
      end else if (xfer && (cmd_op == OP_CLEAR)) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               w[i][j] <= '0;
         pattern_count  <= '0;
         store_overflow <= 1'b0;
      end
   end

   // Recall datapath: probe load, per-cycle neuron update, sweep bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neuron_states <= '0;
         idx           <= '0;
         changed       <= 1'b0;
         sweep_count   <= '0;
         converged     <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            if (xfer && (cmd_op == OP_RECALL)) begin
               neuron_states <= pattern_input;
               idx           <= '0;
               changed       <= 1'b0;
               sweep_count   <= '0;
               converged     <= 1'b0;
            end
         end else begin
            neuron_states[idx] <= new_bit;
            if (last_neuron) begin
               sweep_count <= sweep_count + 1'b1;
               if (recall_end) begin
                  done      <= 1'b1;
                  converged <= sweep_stable;
               end else begin
                  idx     <= '0;
                  changed <= 1'b0;
               end
            end else begin
               idx     <= idx + 1'b1;
               changed <= changed | flip;
            end
         end
      end
   end

endmodule

// File: tb/tb_hopfield_recall_engine.sv
// Directed bench for hopfield_recall_engine: one instance with the default
// sweep limit and one with MAX_SWEEPS=1 for the timeout case.
module tb_hopfield_recall_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // default instance (16 neurons, 4 patterns, 8 sweeps)
   logic        a_valid = 1'b0;
   logic [1:0]  a_op    = 2'b11;
   logic [15:0] a_pat   = '0;
   logic        a_ready, a_done, a_conv, a_ovf, a_fsm;
   logic [15:0] a_states;
   logic [3:0]  a_sc;
   logic [2:0]  a_pc;

   // single-sweep instance
   logic        b_valid = 1'b0;
   logic [1:0]  b_op    = 2'b11;
   logic [15:0] b_pat   = '0;
   logic        b_ready, b_done, b_conv, b_ovf, b_fsm;
   logic [15:0] b_states;
   logic [0:0]  b_sc;
   logic [2:0]  b_pc;

   int errors = 0;
   int checks = 0;

   hopfield_recall_engine #(.NEURON_COUNT(16), .MAX_PATTERNS(4), .MAX_SWEEPS(8)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
      .cmd_op(a_op), .pattern_input(a_pat), .neuron_states(a_states),
      .done(a_done), .converged(a_conv), .sweep_count(a_sc),
      .pattern_count(a_pc), .store_overflow(a_ovf), .fsm_state(a_fsm)
   );

   hopfield_recall_engine #(.NEURON_COUNT(16), .MAX_PATTERNS(4), .MAX_SWEEPS(1)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .cmd_op(b_op), .pattern_input(b_pat), .neuron_states(b_states),
      .done(b_done), .converged(b_conv), .sweep_count(b_sc),
      .pattern_count(b_pc), .store_overflow(b_ovf), .fsm_state(b_fsm)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one command transfer on the default instance (called while idle)
   task automatic send(input logic [1:0] op, input logic [15:0] pat);
      a_valid = 1'b1;
      a_op    = op;
      a_pat   = pat;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      a_op    = 2'b11;
   endtask

   // cycles after the transfer edge until done is seen, bounded
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (a_done !== 1'b1 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic recall_check(input string tag, input logic [15:0] probe,
                               input int exp_cyc, input logic [15:0] exp_states,
                               input logic exp_conv, input logic [3:0] exp_sc);
      int cyc;
      send(2'b01, probe);
      wait_done(cyc);
      check({tag, "_done_seen"}, a_done, 1'b1);
      check({tag, "_latency"}, cyc, exp_cyc);
      check({tag, "_states"}, a_states, exp_states);
      check({tag, "_converged"}, a_conv, exp_conv);
      check({tag, "_sweeps"}, a_sc, exp_sc);
      check({tag, "_ready"}, a_ready, 1'b1);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, a_done, 1'b0);
   endtask

   initial begin
      int          cyc;
      int          ready_seen;
      logic [15:0] mid;
      logic [15:0] pats [5];

      // reset
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_states", a_states, 16'h0000);
      check("rst_ready", a_ready, 1'b1);
      check("rst_done", a_done, 1'b0);
      check("rst_conv", a_conv, 1'b0);
      check("rst_sweeps", a_sc, 4'd0);
      check("rst_pcount", a_pc, 3'd0);
      check("rst_ovf", a_ovf, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // empty weights: every field is zero, probe comes back unchanged
      recall_check("empty_1234", 16'h1234, 16, 16'h1234, 1'b1, 4'd1);

      // no-op transfer changes nothing
      send(2'b11, 16'hFFFF);
      check("noop_states", a_states, 16'h1234);
      check("noop_pcount", a_pc, 3'd0);
      check("noop_conv", a_conv, 1'b1);
      check("noop_sweeps", a_sc, 4'd1);
      check("noop_ready", a_ready, 1'b1);

      // store FF00, recall the stored pattern itself
      send(2'b00, 16'hFF00);
      check("store1_pcount", a_pc, 3'd1);
      check("store1_ready", a_ready, 1'b1);
      recall_check("recall_ff00", 16'hFF00, 16, 16'hFF00, 1'b1, 4'd1);

      // noisy probe FF03: bits 0,1 flip in sweep 1, sweep 2 is stable.
      // A no-op is offered for the whole recall and must wait for done.
      send(2'b01, 16'hFF03);
      a_valid = 1'b1;
      a_op    = 2'b11;
      a_pat   = 16'h0000;
      cyc = 0;
      ready_seen = 0;
      mid = '0;
      while (a_done !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 16) mid = a_states;
         if (a_done !== 1'b1 && a_ready === 1'b1) ready_seen++;
      end
      check("noisy_done_seen", a_done, 1'b1);
      check("noisy_after_sweep1", mid, 16'hFF00);
      check("noisy_latency", cyc, 32);
      check("noisy_states", a_states, 16'hFF00);
      check("noisy_conv", a_conv, 1'b1);
      check("noisy_sweeps", a_sc, 4'd2);
      check("noisy_ready_low_in_recall", ready_seen, 0);
      check("noisy_ready_on_done", a_ready, 1'b1);
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      check("held_noop_done_low", a_done, 1'b0);
      check("held_noop_ready", a_ready, 1'b1);
      check("held_noop_states", a_states, 16'hFF00);
      check("held_noop_conv", a_conv, 1'b1);
      check("held_noop_pcount", a_pc, 3'd1);

      // reset in the middle of sweep 1
      send(2'b01, 16'hFF03);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_states", a_states, 16'h0000);
      check("midrst_ready", a_ready, 1'b1);
      check("midrst_pcount", a_pc, 3'd0);
      check("midrst_done", a_done, 1'b0);
      check("midrst_sweeps", a_sc, 4'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      recall_check("after_rst_1234", 16'h1234, 16, 16'h1234, 1'b1, 4'd1);

      // five stores back-to-back; the fifth must overflow and not train.
      // First four give +4 inside each byte half and 0 across halves.
      pats[0] = 16'hFFFF;
      pats[1] = 16'h0000;
      pats[2] = 16'hFF00;
      pats[3] = 16'h00FF;
      pats[4] = 16'h0F0F;
      a_valid = 1'b1;
      a_op    = 2'b00;
      for (int k = 0; k < 5; k++) begin
         a_pat = pats[k];
         @(posedge clk);
         #1;
      end
      a_valid = 1'b0;
      a_op    = 2'b11;
      check("ovf_pcount", a_pc, 3'd4);
      check("ovf_flag", a_ovf, 1'b1);
      // With only the first four stored, 0F0F relaxes to 0000 in one
      // sweep (each half's minority ones are pulled down) and is stable next.
      recall_check("ovf_recall_0f0f", 16'h0F0F, 32, 16'h0000, 1'b1, 4'd2);

      // clear
      send(2'b10, 16'h0000);
      check("clear_pcount", a_pc, 3'd0);
      check("clear_ovf", a_ovf, 1'b0);
      check("clear_states_kept", a_states, 16'h0000);
      recall_check("clear_recall_a5a5", 16'hA5A5, 16, 16'hA5A5, 1'b1, 4'd1);

      // single-sweep instance: same noisy probe times out after one sweep
      b_valid = 1'b1;
      b_op    = 2'b00;
      b_pat   = 16'hFF00;
      @(posedge clk);
      #1;
      b_op    = 2'b01;
      b_pat   = 16'hFF03;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_op    = 2'b11;
      cyc = 0;
      while (b_done !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("tmo_done_seen", b_done, 1'b1);
      check("tmo_latency", cyc, 16);
      check("tmo_conv", b_conv, 1'b0);
      check("tmo_sweeps", b_sc, 1'b1);
      check("tmo_states", b_states, 16'hFF00);
      check("tmo_pcount", b_pc, 3'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hopfield_recall_engine.md
# hopfield_recall_engine

Parametrised Hopfield associative memory: stores up to MAX_PATTERNS binary patterns by Hebbian learning and recalls the nearest stored pattern from a noisy probe via sequential (one-neuron-per-cycle) updates, with convergence detection and a sweep limit. It is the successor to the fixed-size, free-running HopfieldNetwork: it adds a command handshake, on-chip training, clear, convergence/timeout reporting and capacity tracking.

## Interface
- NEURON_COUNT, 16, number of neurons (N); ≥2
- MAX_PATTERNS, 4, storable patterns before overflow; ≥1
- MAX_SWEEPS, 8, recall sweep limit before timeout; ≥1
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  engine idle; a command transfers on an edge with cmd_valid && cmd_ready
- cmd_op  input  2  00 store, 01 recall, 10 clear, 11 no-op (accepted, no effect)
- pattern_input  input  N  pattern to store or recall probe; sampled only at transfer
- neuron_states  output  N  current network state (live during recall)
- done  output  1  one-cycle pulse at end of a recall
- converged  output  1  valid from done until next recall accept: 1 = stable sweep, 0 = timeout
- sweep_count  output  clog2(MAX_SWEEPS+1)  sweeps executed by last/current recall
- pattern_count  output  clog2(MAX_PATTERNS+1)  patterns stored
- store_overflow  output  1  sticky: store attempted with pattern_count == MAX_PATTERNS

## Operation
- Bipolar encoding: bit 1 = +1, bit 0 = −1.
- Weights: N×N signed, width WW = clog2(MAX_PATTERNS+1)+1; diagonal always 0; range ±MAX_PATTERNS, no saturation needed.
- States: IDLE, RECALL. cmd_ready = (state == IDLE).
- Store (IDLE, transfer): if pattern_count < MAX_PATTERNS, every w[i][j] (i≠j) += +1 if x_i == x_j else −1; pattern_count++. Otherwise weights unchanged, store_overflow ← 1. Stays IDLE; no done.
- Clear (IDLE, transfer): all weights ← 0, pattern_count ← 0, store_overflow ← 0. neuron_states unchanged. Stays IDLE.
- Recall transfer: neuron_states ← pattern_input, idx ← 0, sweep_count ← 0, changed ← 0, converged ← 0, state ← RECALL.
- RECALL, each cycle: h = Σ_j w[idx][j]·s_j (sum width WW+clog2(N)+1, signed). s_idx ← 1 if h>0, 0 if h<0, unchanged if h==0. changed |= (bit flipped). idx++.
- End of sweep (idx == N−1 update edge): sweep_count++. If no flip in the sweep (including this cycle) → converged ← 1, done, IDLE. Else if sweep_count+1 == MAX_SWEEPS → converged ← 0, done, IDLE. Else idx ← 0, changed ← 0, continue.
- cmd_valid while in RECALL: no transfer; the requester holds cmd_valid/cmd_op/pattern_input until accepted.
- Reset (any time, including mid-recall): aborts; weights 0, neuron_states 0, pattern_count 0, store_overflow 0, done 0, converged 0, sweep_count 0, state IDLE (cmd_ready 1).

## Timing
- Store/clear: effect visible the cycle after transfer edge; cmd_ready stays 1, so back-to-back commands accept every cycle.
- Recall: transfer at edge E; neuron k updated at edge E+1+k+N·s (sweep s, 0-based). Recall of K sweeps ends at edge E+K·N; done, cmd_ready, final neuron_states, converged and sweep_count valid in the cycle after it.
- Minimum recall latency N cycles, maximum MAX_SWEEPS·N.
- done is high exactly one cycle; a new command may transfer on that same cycle's closing edge.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-recall (N=16): assert rst during sweep 1 -> asynchronously neuron_states=0, cmd_ready=1, pattern_count=0, done=0, all later recalls on empty weights return the probe unchanged.
- Store 16'hFF00, recall 16'hFF00 -> done 16 cycles after accept, converged=1, sweep_count=1, neuron_states=16'hFF00.
- Same weights, recall 16'hFF03 -> neuron_states=16'hFF00 after sweep 1, done after 32 cycles, converged=1, sweep_count=2; cmd_valid held during recall not accepted until done cycle.
- MAX_SWEEPS=1, store 16'hFF00, recall 16'hFF03 -> done after 16 cycles, converged=0, sweep_count=1, neuron_states=16'hFF00.
- MAX_PATTERNS=4: store 5 distinct patterns back-to-back -> pattern_count=4, store_overflow=1, weights equal to first four only; clear -> pattern_count=0, store_overflow=0, recall 16'hA5A5 returns 16'hA5A5 with converged=1, sweep_count=1.
- Empty weights, recall 16'h1234 -> every h=0, neuron_states=16'h1234, converged=1, sweep_count=1; cmd_op=11 transfer -> no state change.
